// File: rtl/his_builder_pp.sv
// Ping-pong per-pixel histogram builder: hits accumulate in one bank while the other drains (clear-on-read).
// Optional macro HIS_SATURATE_EN: bin counts saturate at all-ones instead of wrapping modulo 2^CW.
module his_builder_pp #(
  parameter int NB       = 16,
  parameter int PIXELS   = 4,
  parameter int DATA_NUM = 2,
  parameter int ACQ_NUM  = 8,
  parameter int CW       = 8,
  localparam int AW      = $clog2(NB),
  localparam int PW      = $clog2(PIXELS)
) (
  input  logic          clk,
  input  logic          res,
  input  logic          wr_en,
  input  logic [AW-1:0] addr,
  input  logic          rd_ready,
  output logic          rd_valid,
  output logic [CW-1:0] rd_data,
  output logic [PW-1:0] rd_pixel,
  output logic [AW-1:0] rd_bin,
  output logic          rd_last,
  output logic          his_num,
  output logic          frame_done,
  output logic          busy,
  output logic          overflow
);
  localparam int DEPTH = PIXELS * NB;
  localparam int DW    = $clog2(DEPTH);
  localparam int IW    = (DATA_NUM > 1) ? $clog2(DATA_NUM) : 1;
  localparam int QW    = (ACQ_NUM > 1) ? $clog2(ACQ_NUM) : 1;

  typedef enum logic {S_INIT, S_ACCUM} ctl_e;
  typedef enum logic {R_IDLE, R_DRAIN} rd_e;

  ctl_e          ctl_q, ctl_d;
  rd_e           rd_st_q, rd_st_d;
  logic [DW-1:0] init_cnt_q, init_cnt_d;
  logic [IW-1:0] in_cnt_q, in_cnt_d;
  logic [PW-1:0] pix_cnt_q, pix_cnt_d;
  logic [QW-1:0] acq_cnt_q, acq_cnt_d;
  logic          his_num_q, his_num_d;
  logic          pend_q, pend_d;
  logic          swap_q, swap_d;
  logic          frame_done_q, frame_done_d;
  logic          overflow_q, overflow_d;
  logic          drain_bank_q, drain_bank_d;
  logic          rd_valid_q, rd_valid_d;
  logic [DW-1:0] rd_ptr_q, rd_ptr_d;
  logic          a_valid_q, a_valid_d;
  logic [DW-1:0] a_idx_q, a_idx_d;
  logic          a_bank_q, a_bank_d;
  logic          a_fwd_q, a_fwd_d;
  logic [CW-1:0] last_w_q, last_w_d;

  logic [CW-1:0] bank_rq [2];
  logic          hit_acc, hit_wr, in_range, wrap, drain_free, swap_go, rd_hs, ptr_last;
  logic [DW-1:0] hit_idx, drain_raddr;
  logic [CW-1:0] a_base, a_new;

  function automatic logic [CW-1:0] bump(input logic [CW-1:0] v);
`ifdef HIS_SATURATE_EN
    return (v == {CW{1'b1}}) ? v : v + 1'b1;
`else
    return v + 1'b1;
`endif
  endfunction

  // A hit is taken only in ACCUM and never while a completed frame waits for the drain bank.
  assign hit_acc    = wr_en && (ctl_q == S_ACCUM) && !pend_q;
  assign in_range   = {1'b0, addr} < (AW+1)'(NB);
  assign hit_wr     = hit_acc && in_range;
  assign hit_idx    = DW'(pix_cnt_q) * DW'(NB) + DW'(addr);
  assign wrap       = hit_acc && (in_cnt_q == IW'(DATA_NUM-1)) && (pix_cnt_q == PW'(PIXELS-1))
                      && (acq_cnt_q == QW'(ACQ_NUM-1));
  assign drain_free = (rd_st_q == R_IDLE) && !swap_q && !frame_done_q;
  assign swap_go    = (wrap || pend_q) && drain_free;
  assign a_base     = a_fwd_q ? last_w_q : bank_rq[a_bank_q];
  assign a_new      = bump(a_base);
  assign rd_hs      = rd_valid_q && rd_ready;
  assign ptr_last   = (rd_ptr_q == DW'(DEPTH-1));
  // Re-reading the held index keeps the registered RAM output stable until accepted.
  assign drain_raddr = rd_hs ? rd_ptr_q + 1'b1 : rd_ptr_q;

  always_comb begin
    ctl_d        = ctl_q;
    rd_st_d      = rd_st_q;
    init_cnt_d   = init_cnt_q;
    in_cnt_d     = in_cnt_q;
    pix_cnt_d    = pix_cnt_q;
    acq_cnt_d    = acq_cnt_q;
    his_num_d    = his_num_q;
    pend_d       = pend_q;
    overflow_d   = overflow_q;
    drain_bank_d = drain_bank_q;
    rd_valid_d   = rd_valid_q;
    rd_ptr_d     = rd_ptr_q;
    swap_d       = swap_go;
    frame_done_d = swap_q;
    a_valid_d    = hit_wr;
    a_idx_d      = hit_idx;
    a_bank_d     = his_num_q;
    a_fwd_d      = hit_wr && a_valid_q && (a_idx_q == hit_idx) && (a_bank_q == his_num_q);
    last_w_d     = a_valid_q ? a_new : last_w_q;

    case (ctl_q)
      S_INIT: begin
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == DW'(DEPTH-1)) begin
          init_cnt_d = '0;
          ctl_d      = S_ACCUM;
        end
      end
      default: ;
    endcase

    if (hit_acc) begin
      in_cnt_d = in_cnt_q + 1'b1;
      if (in_cnt_q == IW'(DATA_NUM-1)) begin
        in_cnt_d  = '0;
        pix_cnt_d = pix_cnt_q + 1'b1;
        if (pix_cnt_q == PW'(PIXELS-1)) begin
          pix_cnt_d = '0;
          acq_cnt_d = acq_cnt_q + 1'b1;
          if (acq_cnt_q == QW'(ACQ_NUM-1)) acq_cnt_d = '0;
        end
      end
    end

    if (swap_go) begin
      his_num_d    = ~his_num_q;
      drain_bank_d = his_num_q;
      pend_d       = 1'b0;
    end else if (wrap) begin
      pend_d     = 1'b1;
      overflow_d = 1'b1;
    end

    case (rd_st_q)
      R_IDLE: begin
        if (frame_done_q) begin
          rd_st_d    = R_DRAIN;
          rd_ptr_d   = '0;
          rd_valid_d = 1'b0;
        end
      end
      R_DRAIN: begin
        if (!rd_valid_q) begin
          rd_valid_d = 1'b1;
        end else if (rd_hs) begin
          if (ptr_last) begin
            rd_st_d    = R_IDLE;
            rd_valid_d = 1'b0;
            rd_ptr_d   = '0;
          end else begin
            rd_ptr_d = rd_ptr_q + 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      ctl_q        <= S_INIT;
      rd_st_q      <= R_IDLE;
      init_cnt_q   <= '0;
      in_cnt_q     <= '0;
      pix_cnt_q    <= '0;
      acq_cnt_q    <= '0;
      his_num_q    <= 1'b0;
      pend_q       <= 1'b0;
      swap_q       <= 1'b0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      drain_bank_q <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_ptr_q     <= '0;
      a_valid_q    <= 1'b0;
      a_idx_q      <= '0;
      a_bank_q     <= 1'b0;
      a_fwd_q      <= 1'b0;
      last_w_q     <= '0;
    end else begin
      ctl_q        <= ctl_d;
      rd_st_q      <= rd_st_d;
      init_cnt_q   <= init_cnt_d;
      in_cnt_q     <= in_cnt_d;
      pix_cnt_q    <= pix_cnt_d;
      acq_cnt_q    <= acq_cnt_d;
      his_num_q    <= his_num_d;
      pend_q       <= pend_d;
      swap_q       <= swap_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
      drain_bank_q <= drain_bank_d;
      rd_valid_q   <= rd_valid_d;
      rd_ptr_q     <= rd_ptr_d;
      a_valid_q    <= a_valid_d;
      a_idx_q      <= a_idx_d;
      a_bank_q     <= a_bank_d;
      a_fwd_q      <= a_fwd_d;
      last_w_q     <= last_w_d;
    end
  end

  // Each bank has one read and one write port; accumulate and drain never target the same bank.
  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    logic [CW-1:0] mem [DEPTH];
    logic [CW-1:0] rq;
    logic          we;
    logic [DW-1:0] waddr;
    logic [DW-1:0] raddr;
    logic [CW-1:0] wdata;

    always_comb begin
      we    = 1'b0;
      waddr = a_idx_q;
      wdata = a_new;
      if (ctl_q == S_INIT) begin
        we    = 1'b1;
        waddr = init_cnt_q;
        wdata = '0;
      end else if (a_valid_q && (a_bank_q == 1'(gi))) begin
        we = 1'b1;
      end else if (rd_hs && (drain_bank_q == 1'(gi))) begin
        we    = 1'b1;
        waddr = rd_ptr_q;
        wdata = '0;
      end
    end

    assign raddr = (his_num_q == 1'(gi)) ? hit_idx : drain_raddr;

    always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      rq <= mem[raddr];
    end

    assign bank_rq[gi] = rq;
  end

  assign rd_valid   = rd_valid_q;
  assign rd_data    = rd_valid_q ? bank_rq[drain_bank_q] : '0;
  assign rd_pixel   = PW'(rd_ptr_q / DW'(NB));
  assign rd_bin     = AW'(rd_ptr_q % DW'(NB));
  assign rd_last    = rd_valid_q && ptr_last;
  assign his_num    = his_num_q;
  assign frame_done = frame_done_q;
  assign busy       = (ctl_q == S_INIT);
  assign overflow   = overflow_q;
endmodule

// File: tb/tb_his_builder_pp.sv
// Directed bench for his_builder_pp: a CW=4 instance plus a CW=2 twin on the same stimulus.
module tb_his_builder_pp;
  localparam int NB = 4, PIXELS = 2, DATA_NUM = 2, ACQ_NUM = 3, CW = 4, CW2 = 2;
  localparam int AW = 2, PW = 1;

  logic clk = 1'b0, res = 1'b0, wr_en = 1'b0, rd_ready = 1'b1;
  logic [AW-1:0] addr = '0;

  logic rd_valid, rd_last, his_num, frame_done, busy, overflow;
  logic [CW-1:0] rd_data;
  logic [PW-1:0] rd_pixel;
  logic [AW-1:0] rd_bin;

  logic rd_valid2, rd_last2, his_num2, frame_done2, busy2, overflow2;
  logic [CW2-1:0] rd_data2;
  logic [PW-1:0] rd_pixel2;
  logic [AW-1:0] rd_bin2;

  int n_chk = 0, n_bad = 0, fd_cnt = 0, fd0 = 0;

  his_builder_pp #(.NB(NB), .PIXELS(PIXELS), .DATA_NUM(DATA_NUM), .ACQ_NUM(ACQ_NUM), .CW(CW)) u_dut (
    .clk(clk), .res(res), .wr_en(wr_en), .addr(addr), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_pixel(rd_pixel), .rd_bin(rd_bin),
    .rd_last(rd_last), .his_num(his_num), .frame_done(frame_done), .busy(busy), .overflow(overflow)
  );

  his_builder_pp #(.NB(NB), .PIXELS(PIXELS), .DATA_NUM(DATA_NUM), .ACQ_NUM(ACQ_NUM), .CW(CW2)) u_dut2 (
    .clk(clk), .res(res), .wr_en(wr_en), .addr(addr), .rd_ready(rd_ready),
    .rd_valid(rd_valid2), .rd_data(rd_data2), .rd_pixel(rd_pixel2), .rd_bin(rd_bin2),
    .rd_last(rd_last2), .his_num(his_num2), .frame_done(frame_done2), .busy(busy2), .overflow(overflow2)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_done) fd_cnt <= fd_cnt + 1;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  function automatic int narrow(input int v);
`ifdef HIS_SATURATE_EN
    return (v > 3) ? 3 : v;
`else
    return v % 4;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input string tag);
    int cnt;
    res = 1'b1; wr_en = 1'b1; addr = 2'd3;
    #1;
    check({tag, "_rd_valid"}, rd_valid, 0);
    check({tag, "_rd_data"}, rd_data, 0);
    check({tag, "_rd_pos"}, {rd_pixel, rd_bin}, 0);
    check({tag, "_rd_last"}, rd_last, 0);
    check({tag, "_his_num"}, his_num, 0);
    check({tag, "_frame_done"}, frame_done, 0);
    check({tag, "_busy"}, busy, 1);
    check({tag, "_overflow"}, overflow, 0);
    check({tag, "_twin_state"}, {his_num2, frame_done2, busy2, overflow2}, 4'b0010);
    step(); step();
    res = 1'b0;
    cnt = 0;
    while (busy && cnt < 50) begin
      cnt++;
      step();
    end
    wr_en = 1'b0;
    check({tag, "_busy_cycles"}, cnt, 8);
  endtask

  task automatic send_hits(input int n, input int a);
    for (int i = 0; i < n; i++) begin
      wr_en = 1'b1;
      addr  = AW'(a);
      step();
    end
    wr_en = 1'b0;
  endtask

  task automatic wait_fd(input string tag);
    int s = 0, lat = 0;
    while (!frame_done && s < 50) begin step(); s++; end
    check({tag, "_fd_delay"}, s, 1);
    while (!rd_valid && lat < 50) begin step(); lat++; end
    check({tag, "_rdv_lat"}, lat, 2);
  endtask

  // Frames here put cnt hits into one bin of each pixel; every other word must read 0.
  task automatic read_frame(input string tag, input int hot, input int cnt);
    int k = 0, g = 0, g0 = 0, e;
    while (k < 8 && g < 300) begin
      if (rd_valid && rd_ready) begin
        if (k == 0) g0 = g;
        e = ((k % 4) == hot) ? cnt : 0;
        $display("%s word %0d pix=%0d bin=%0d data=%0d data2=%0d last=%0d",
                 tag, k, rd_pixel, rd_bin, rd_data, rd_data2, rd_last);
        check({tag, "_data"}, rd_data, e);
        check({tag, "_pos"}, {rd_pixel, rd_bin}, k);
        check({tag, "_last"}, rd_last, (k == 7) ? 1 : 0);
        check({tag, "_data2"}, rd_data2, narrow(e));
        check({tag, "_twin"}, {rd_valid2, rd_last2, rd_pixel2, rd_bin2}, {1'b1, (k == 7) ? 1'b1 : 1'b0, 3'(k)});
        k++;
      end
      step();
      g++;
    end
    check({tag, "_words"}, k, 8);
    check({tag, "_tput"}, g - g0, 8);
  endtask

  initial begin
    int g;
    #2;
    apply_reset("por");

    fd0 = fd_cnt;
    send_hits(12, 1);
    wait_fd("f1");
    check("f1_his_num", his_num, 1);
    read_frame("f1", 1, 6);
    step(); step(); step();
    check("f1_fd_once", fd_cnt - fd0, 1);
    check("f1_idle", rd_valid, 0);

    send_hits(12, 2);
    wait_fd("f2");
    check("f2_his_num", his_num, 0);
    read_frame("f2", 2, 6);

    send_hits(12, 0);
    wait_fd("f3");
    check("f3_his_num", his_num, 1);
    read_frame("f3", 0, 6);

    rd_ready = 1'b0;
    fd0 = fd_cnt;
    send_hits(12, 1);
    send_hits(12, 3);
    step();
    check("ov_flag", overflow, 1);
    check("ov_twin_flag", overflow2, 1);
    send_hits(12, 0);
    step();
    check("ov_his_hold", his_num, 0);
    check("ov_fd_count", fd_cnt - fd0, 1);
    check("ov_hold_valid", rd_valid, 1);
    check("ov_hold_pos", {rd_pixel, rd_bin}, 0);
    rd_ready = 1'b1;
    read_frame("ovA", 1, 6);
    read_frame("ovB", 3, 6);
    check("ov_fd_after", fd_cnt - fd0, 2);
    check("ov_his_after", his_num, 1);
    send_hits(12, 2);
    wait_fd("ovC");
    read_frame("ovC", 2, 6);
    check("ov_sticky", overflow, 1);

    send_hits(12, 1);
    g = 0;
    while (!rd_valid && g < 50) begin step(); g++; end
    check("mid_rdv_seen", rd_valid, 1);
    step(); step(); step();
    check("mid_pos", {rd_pixel, rd_bin}, 3);
    apply_reset("mid");
    send_hits(12, 3);
    wait_fd("f5");
    check("f5_his_num", his_num, 1);
    read_frame("f5", 3, 6);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
